// File: rtl/fft4_twiddle_pipe.sv
// Pipelined 4-point complex DFT: per-lane twiddle multiply, radix-2 butterfly,
// exact -j rotation, second butterfly. Three registered stages, one set per clock.
module fft4_twiddle_pipe #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned TW_WIDTH = 16,
  parameter int unsigned FRAC     = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [WIDTH-1:0]    in_re0,
  input  logic signed [WIDTH-1:0]    in_re1,
  input  logic signed [WIDTH-1:0]    in_re2,
  input  logic signed [WIDTH-1:0]    in_re3,
  input  logic signed [WIDTH-1:0]    in_im0,
  input  logic signed [WIDTH-1:0]    in_im1,
  input  logic signed [WIDTH-1:0]    in_im2,
  input  logic signed [WIDTH-1:0]    in_im3,
  input  logic signed [TW_WIDTH-1:0] tw_re0,
  input  logic signed [TW_WIDTH-1:0] tw_re1,
  input  logic signed [TW_WIDTH-1:0] tw_re2,
  input  logic signed [TW_WIDTH-1:0] tw_re3,
  input  logic signed [TW_WIDTH-1:0] tw_im0,
  input  logic signed [TW_WIDTH-1:0] tw_im1,
  input  logic signed [TW_WIDTH-1:0] tw_im2,
  input  logic signed [TW_WIDTH-1:0] tw_im3,
  output logic                       out_valid,
  output logic signed [WIDTH+1:0]    out_re0,
  output logic signed [WIDTH+1:0]    out_re1,
  output logic signed [WIDTH+1:0]    out_re2,
  output logic signed [WIDTH+1:0]    out_re3,
  output logic signed [WIDTH+1:0]    out_im0,
  output logic signed [WIDTH+1:0]    out_im1,
  output logic signed [WIDTH+1:0]    out_im2,
  output logic signed [WIDTH+1:0]    out_im3
);

  localparam int unsigned PW = WIDTH + TW_WIDTH + 1;
  localparam int unsigned W1 = WIDTH + 1;
  localparam int unsigned W2 = WIDTH + 2;
  // Half an LSB of the twiddle format, for round-half-up before the shift
  localparam logic signed [PW-1:0] RND = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  logic signed [WIDTH-1:0]    x_re [4];
  logic signed [WIDTH-1:0]    x_im [4];
  logic signed [TW_WIDTH-1:0] w_re [4];
  logic signed [TW_WIDTH-1:0] w_im [4];

  assign x_re[0] = in_re0;  assign x_re[1] = in_re1;
  assign x_re[2] = in_re2;  assign x_re[3] = in_re3;
  assign x_im[0] = in_im0;  assign x_im[1] = in_im1;
  assign x_im[2] = in_im2;  assign x_im[3] = in_im3;
  assign w_re[0] = tw_re0;  assign w_re[1] = tw_re1;
  assign w_re[2] = tw_re2;  assign w_re[3] = tw_re3;
  assign w_im[0] = tw_im0;  assign w_im[1] = tw_im1;
  assign w_im[2] = tw_im2;  assign w_im[3] = tw_im3;

  logic [2:0]              v_q, v_d;
  logic signed [WIDTH-1:0] y_re_q [4];
  logic signed [WIDTH-1:0] y_re_d [4];
  logic signed [WIDTH-1:0] y_im_q [4];
  logic signed [WIDTH-1:0] y_im_d [4];
  logic signed [W1-1:0]    s0_re_q, s0_im_q, s1_re_q, s1_im_q;
  logic signed [W1-1:0]    d0_re_q, d0_im_q, d1_re_q, d1_im_q;
  logic signed [W1-1:0]    s0_re_d, s0_im_d, s1_re_d, s1_im_d;
  logic signed [W1-1:0]    d0_re_d, d0_im_d, d1_re_d, d1_im_d;
  logic signed [W2-1:0]    xo_re_q [4];
  logic signed [W2-1:0]    xo_re_d [4];
  logic signed [W2-1:0]    xo_im_q [4];
  logic signed [W2-1:0]    xo_im_d [4];

  // Stage 0: full-precision complex multiply, round, wrap to WIDTH
  always_comb begin
    logic signed [PW-1:0] xr, xi, wr, wi, acc_re, acc_im;
    xr = '0; xi = '0; wr = '0; wi = '0; acc_re = '0; acc_im = '0;
    for (int k = 0; k < 4; k++) begin
      xr        = PW'(x_re[k]);
      xi        = PW'(x_im[k]);
      wr        = PW'(w_re[k]);
      wi        = PW'(w_im[k]);
      acc_re    = xr * wr - xi * wi + RND;
      acc_im    = xr * wi + xi * wr + RND;
      y_re_d[k] = WIDTH'(acc_re >>> FRAC);
      y_im_d[k] = WIDTH'(acc_im >>> FRAC);
    end
  end

  // Stage 1: first butterfly with one bit of growth
  always_comb begin
    s0_re_d = W1'(y_re_q[0]) + W1'(y_re_q[2]);
    s0_im_d = W1'(y_im_q[0]) + W1'(y_im_q[2]);
    s1_re_d = W1'(y_re_q[1]) + W1'(y_re_q[3]);
    s1_im_d = W1'(y_im_q[1]) + W1'(y_im_q[3]);
    d0_re_d = W1'(y_re_q[0]) - W1'(y_re_q[2]);
    d0_im_d = W1'(y_im_q[0]) - W1'(y_im_q[2]);
    d1_re_d = W1'(y_re_q[1]) - W1'(y_re_q[3]);
    d1_im_d = W1'(y_im_q[1]) - W1'(y_im_q[3]);
  end

  // Stage 2: d1 * -j folded in as (d1_im, -d1_re), then the second butterfly
  always_comb begin
    xo_re_d[0] = W2'(s0_re_q) + W2'(s1_re_q);
    xo_im_d[0] = W2'(s0_im_q) + W2'(s1_im_q);
    xo_re_d[2] = W2'(s0_re_q) - W2'(s1_re_q);
    xo_im_d[2] = W2'(s0_im_q) - W2'(s1_im_q);
    xo_re_d[1] = W2'(d0_re_q) + W2'(d1_im_q);
    xo_im_d[1] = W2'(d0_im_q) - W2'(d1_re_q);
    xo_re_d[3] = W2'(d0_re_q) - W2'(d1_im_q);
    xo_im_d[3] = W2'(d0_im_q) + W2'(d1_re_q);
  end

  always_comb begin
    v_d = {v_q[1:0], in_valid};
  end

  // Data registers load every cycle; only the valid chain carries set identity
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      y_re_q  <= '{default: '0};
      y_im_q  <= '{default: '0};
      s0_re_q <= '0;  s0_im_q <= '0;  s1_re_q <= '0;  s1_im_q <= '0;
      d0_re_q <= '0;  d0_im_q <= '0;  d1_re_q <= '0;  d1_im_q <= '0;
      xo_re_q <= '{default: '0};
      xo_im_q <= '{default: '0};
    end else begin
      v_q     <= v_d;
      y_re_q  <= y_re_d;
      y_im_q  <= y_im_d;
      s0_re_q <= s0_re_d;  s0_im_q <= s0_im_d;
      s1_re_q <= s1_re_d;  s1_im_q <= s1_im_d;
      d0_re_q <= d0_re_d;  d0_im_q <= d0_im_d;
      d1_re_q <= d1_re_d;  d1_im_q <= d1_im_d;
      xo_re_q <= xo_re_d;
      xo_im_q <= xo_im_d;
    end
  end

  assign out_valid = v_q[2];
  assign out_re0   = xo_re_q[0];
  assign out_re1   = xo_re_q[1];
  assign out_re2   = xo_re_q[2];
  assign out_re3   = xo_re_q[3];
  assign out_im0   = xo_im_q[0];
  assign out_im1   = xo_im_q[1];
  assign out_im2   = xo_im_q[2];
  assign out_im3   = xo_im_q[3];

endmodule

// File: tb/tb_fft4_twiddle_pipe.sv
// Scoreboard bench for fft4_twiddle_pipe: directed vectors push hand-computed
// spectra; a monitor pops and compares whenever out_valid is seen.
module tb_fft4_twiddle_pipe;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned TW_WIDTH = 16;
  localparam int unsigned FRAC     = 14;
  localparam int          UNITY    = 16384;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic signed [WIDTH-1:0]    in_re0, in_re1, in_re2, in_re3;
  logic signed [WIDTH-1:0]    in_im0, in_im1, in_im2, in_im3;
  logic signed [TW_WIDTH-1:0] tw_re0, tw_re1, tw_re2, tw_re3;
  logic signed [TW_WIDTH-1:0] tw_im0, tw_im1, tw_im2, tw_im3;
  logic                       out_valid;
  logic signed [WIDTH+1:0]    out_re0, out_re1, out_re2, out_re3;
  logic signed [WIDTH+1:0]    out_im0, out_im1, out_im2, out_im3;

  fft4_twiddle_pipe #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_re0(in_re0), .in_re1(in_re1), .in_re2(in_re2), .in_re3(in_re3),
    .in_im0(in_im0), .in_im1(in_im1), .in_im2(in_im2), .in_im3(in_im3),
    .tw_re0(tw_re0), .tw_re1(tw_re1), .tw_re2(tw_re2), .tw_re3(tw_re3),
    .tw_im0(tw_im0), .tw_im1(tw_im1), .tw_im2(tw_im2), .tw_im3(tw_im3),
    .out_valid(out_valid),
    .out_re0(out_re0), .out_re1(out_re1), .out_re2(out_re2), .out_re3(out_re3),
    .out_im0(out_im0), .out_im1(out_im1), .out_im2(out_im2), .out_im3(out_im3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    re [4];
    int    im [4];
    string name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Working vector: inputs, twiddles, expected spectrum
  int xr [4];
  int xi [4];
  int wr [4];
  int wi [4];
  int er [4];
  int ei [4];

  task automatic clear_vec();
    for (int k = 0; k < 4; k++) begin
      xr[k] = 0; xi[k] = 0; wr[k] = UNITY; wi[k] = 0; er[k] = 0; ei[k] = 0;
    end
  endtask

  task automatic set_all(input int re, input int im);
    for (int k = 0; k < 4; k++) begin
      er[k] = re; ei[k] = im;
    end
  endtask

  task automatic send(input string name, input bit push);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_re0 = WIDTH'(xr[0]); in_re1 = WIDTH'(xr[1]); in_re2 = WIDTH'(xr[2]); in_re3 = WIDTH'(xr[3]);
    in_im0 = WIDTH'(xi[0]); in_im1 = WIDTH'(xi[1]); in_im2 = WIDTH'(xi[2]); in_im3 = WIDTH'(xi[3]);
    tw_re0 = TW_WIDTH'(wr[0]); tw_re1 = TW_WIDTH'(wr[1]); tw_re2 = TW_WIDTH'(wr[2]); tw_re3 = TW_WIDTH'(wr[3]);
    tw_im0 = TW_WIDTH'(wi[0]); tw_im1 = TW_WIDTH'(wi[1]); tw_im2 = TW_WIDTH'(wi[2]); tw_im3 = TW_WIDTH'(wi[3]);
    if (push) begin
      for (int k = 0; k < 4; k++) begin
        e.re[k] = er[k]; e.im[k] = ei[k];
      end
      e.name = name;
      q.push_back(e);
    end
  endtask

  task automatic check_idle(input string name);
    n_tests++;
    if (out_valid !== 1'b0 || out_re0 !== '0 || out_re1 !== '0 || out_re2 !== '0 ||
        out_re3 !== '0 || out_im0 !== '0 || out_im1 !== '0 || out_im2 !== '0 || out_im3 !== '0) begin
      n_fail++;
      $display("FAIL %s: out_valid=%0b X0=(%0d,%0d) X1=(%0d,%0d) X2=(%0d,%0d) X3=(%0d,%0d), required all 0",
               name, out_valid, out_re0, out_im0, out_re1, out_im1, out_re2, out_im2, out_re3, out_im3);
    end
  endtask

  // Monitor: one comparison per presented output set
  always @(posedge clk) begin
    exp_t e;
    int   gr [4];
    int   gi [4];
    bit   bad;
    #1;
    if (!rst && out_valid === 1'b1) begin
      gr[0] = out_re0; gr[1] = out_re1; gr[2] = out_re2; gr[3] = out_re3;
      gi[0] = out_im0; gi[1] = out_im1; gi[2] = out_im2; gi[3] = out_im3;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: out_valid=1 X0=(%0d,%0d) with no set outstanding", gr[0], gi[0]);
      end else begin
        e   = q.pop_front();
        bad = 1'b0;
        for (int k = 0; k < 4; k++)
          if (gr[k] != e.re[k] || gi[k] != e.im[k]) bad = 1'b1;
        if (bad) begin
          n_fail++;
          $display("FAIL %s: got X=(%0d,%0d) (%0d,%0d) (%0d,%0d) (%0d,%0d) required (%0d,%0d) (%0d,%0d) (%0d,%0d) (%0d,%0d)",
                   e.name, gr[0], gi[0], gr[1], gi[1], gr[2], gi[2], gr[3], gi[3],
                   e.re[0], e.im[0], e.re[1], e.im[1], e.re[2], e.im[2], e.re[3], e.im[3]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    clear_vec();
    in_re0 = '0; in_re1 = '0; in_re2 = '0; in_re3 = '0;
    in_im0 = '0; in_im1 = '0; in_im2 = '0; in_im3 = '0;
    tw_re0 = '0; tw_re1 = '0; tw_re2 = '0; tw_re3 = '0;
    tw_im0 = '0; tw_im1 = '0; tw_im2 = '0; tw_im3 = '0;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    rst = 1'b0;

    clear_vec(); xr[0] = 1; set_all(1, 0);
    send("impulse", 1'b1);

    clear_vec(); xr[1] = 1;
    er[0] = 1; er[2] = -1; ei[1] = -1; ei[3] = 1;
    send("shifted_impulse", 1'b1);

    clear_vec(); xr[0] = 1; xr[2] = -1; er[1] = 2; er[3] = 2;
    send("cosine", 1'b1);

    clear_vec(); for (int k = 0; k < 4; k++) xr[k] = 1; er[0] = 4;
    send("constant", 1'b1);

    clear_vec(); xr[1] = 100; wr[1] = 0; wi[1] = UNITY;
    ei[0] = 100; er[1] = 100; ei[2] = -100; er[3] = -100;
    send("twiddle_j", 1'b1);

    @(negedge clk); in_valid = 1'b0;

    clear_vec(); xr[0] = 3; wr[0] = 8192; set_all(2, 0);
    send("round_pos", 1'b1);

    clear_vec(); xr[0] = -3; wr[0] = 8192; set_all(-1, 0);
    send("round_neg", 1'b1);

    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);

    // Four back-to-back sets
    clear_vec(); xr[0] = 5; xi[0] = 3; set_all(5, 3);
    send("stream_a", 1'b1);

    clear_vec();
    for (int k = 0; k < 4; k++) begin xr[k] = k + 1; xi[k] = k + 1; end
    er[0] = 10; ei[0] = 10; er[1] = -4; ei[1] = 0; er[2] = -2; ei[2] = -2; er[3] = 0; ei[3] = -4;
    send("stream_b", 1'b1);

    clear_vec(); xi[3] = 7;
    ei[0] = 7; er[1] = -7; ei[2] = -7; er[3] = 7;
    send("stream_c", 1'b1);

    clear_vec(); xr[2] = -50; xi[2] = 20; wr[2] = 0; wi[2] = -UNITY;
    er[0] = 20; ei[0] = 50; er[1] = -20; ei[1] = -50; er[2] = 20; ei[2] = 50; er[3] = -20; ei[3] = -50;
    send("stream_d", 1'b1);

    @(negedge clk); in_valid = 1'b0;
    begin
      int budget;
      budget = 0;
      while (q.size() != 0 && budget < 20) begin
        @(negedge clk); budget++;
      end
      n_tests++;
      if (q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d sets still outstanding, required 0", q.size());
        q.delete();
      end
    end

    // Two sets in flight, then reset: neither may appear
    clear_vec(); xr[0] = 9; send("dropped_a", 1'b0);
    clear_vec(); xr[1] = 9; send("dropped_b", 1'b0);
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_idle("reset_midstream");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_valid: cycle %0d out_valid=%0b required 0", i, out_valid);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
